// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD SS.hh stopwatch with start/stop/clear control and 4-digit display scan
// Ports:
//   clk, rst          - system clock, asynchronous active-high reset
//   start_stop, clear - debounced button levels, act on rising edge
//   digit             - BCD value of the selected digit (to 7-seg decoder)
//   sel               - active-low one-hot digit enable (0=hundredths .. 3=seconds tens)
//   dp                - decimal point, high with the seconds-ones digit
//   bcd               - full count {s_tens, s_ones, tenths, hundredths}
//   running           - high while counting
//   ovf               - sticky wrap flag, cleared by clear
module stopwatch_core #(
    parameter int TICK_DIV = 500000,
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    output logic [3:0]  digit,
    output logic [3:0]  sel,
    output logic        dp,
    output logic [15:0] bcd,
    output logic        running,
    output logic        ovf
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    state_t state, state_d;

    logic ss_q, clr_q, ss_ev, clr_ev, tick, wrap;
    logic h9, t9, o9, s5;
    logic [3:0] hs, ts, os, st;
    logic [15:0] bcd_inc;
    logic [PW-1:0] pre;
    logic [SW-1:0] scnt;
    logic [1:0] idx;

    assign {st, os, ts, hs} = bcd;
    assign running = state == RUN;
    assign tick = running && pre == PMAX;

    always_comb begin
        h9 = hs >= 4'd9;
        t9 = ts >= 4'd9;
        o9 = os >= 4'd9;
        s5 = st >= 4'd5;
        wrap = h9 && t9 && o9 && s5;
        bcd_inc = {(h9 && t9 && o9) ? (s5 ? 4'd0 : st + 4'd1) : st,
                   (h9 && t9) ? (o9 ? 4'd0 : os + 4'd1) : os,
                   h9 ? (t9 ? 4'd0 : ts + 4'd1) : ts,
                   h9 ? 4'd0 : hs + 4'd1};
        // clear outranks start_stop when both events land together
        state_d = clr_ev ? IDLE : ss_ev ? (state == RUN ? PAUSE : RUN) : state;
    end

    // events are registered, so a button seen at edge N moves the FSM at edge N+1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_q <= 1'b0;
            clr_q <= 1'b0;
            ss_ev <= 1'b0;
            clr_ev <= 1'b0;
            state <= IDLE;
        end else begin
            ss_q <= start_stop;
            clr_q <= clear;
            ss_ev <= start_stop & ~ss_q;
            clr_ev <= clear & ~clr_q;
            state <= state_d;
        end
    end

    // prescaler holds in PAUSE so the sub-tick phase survives pause/resume
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
            bcd <= '0;
            ovf <= 1'b0;
        end else if (clr_ev) begin
            pre <= '0;
            bcd <= '0;
            ovf <= 1'b0;
        end else begin
            if (state == IDLE)
                pre <= '0;
            else if (running)
                pre <= tick ? '0 : pre + 1'b1;
            if (tick)
                bcd <= bcd_inc;
            if (tick && wrap)
                ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt <= '0;
            idx <= 2'd0;
            digit <= 4'd0;
            sel <= 4'b1110;
            dp <= 1'b0;
        end else begin
            scnt <= scnt == SMAX ? '0 : scnt + 1'b1;
            if (scnt == SMAX)
                idx <= idx + 2'd1;
            digit <= idx == 2'd0 ? hs : idx == 2'd1 ? ts : idx == 2'd2 ? os : st;
            sel <= ~(4'b0001 << idx);
            dp <= idx == 2'd2;
        end
    end
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: scoreboard bench for stopwatch_core with TICK_DIV=4, SCAN_DIV=2
module tb_stopwatch_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_stop = 1'b0;
    logic clear = 1'b0;
    logic [3:0] digit, sel;
    logic dp, running, ovf;
    logic [15:0] bcd;
    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    stopwatch_core #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear),
        .digit(digit), .sel(sel), .dp(dp), .bcd(bcd), .running(running), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input logic [15:0] b, input logic [3:0] s, input logic [3:0] d,
                                       input logic p, input logic r, input logic o);
        return {5'd0, b, s, d, p, r, o};
    endfunction

    function automatic logic [31:0] snap();
        return pk(bcd, sel, digit, dp, running, ovf);
    endfunction

    task automatic press_start();
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.push_back(pk(16'h0000, 4'b1110, 4'd0, 1'b0, 1'b0, 1'b0));
        e = exp_q.pop_front();
        tests++;
        if (snap() !== e) begin
            fails++;
            $display("FAIL reset_values: got %h expected %h", snap(), e);
        end
        rst = 1'b0;
        exp_q.push_back({15'd0, 1'b0, 16'h0000});
        repeat (100) @(negedge clk);
        e = exp_q.pop_front();
        tests++;
        if ({running, bcd} !== e[16:0]) begin
            fails++;
            $display("FAIL idle_hold: got %h expected %h", {running, bcd}, e[16:0]);
        end
    endtask

    task automatic test_start_count();
        exp_q.push_back(32'd1);
        exp_q.push_back(32'h0009);
        exp_q.push_back(32'h0010);
        press_start();
        e = exp_q.pop_front();
        tests++;
        if (running !== e[0]) begin
            fails++;
            $display("FAIL start_running: got %b expected %b", running, e[0]);
        end
        repeat (39) @(negedge clk);
        e = exp_q.pop_front();
        tests++;
        if (bcd !== e[15:0]) begin
            fails++;
            $display("FAIL count_09: got %h expected %h", bcd, e[15:0]);
        end
        @(negedge clk);
        e = exp_q.pop_front();
        tests++;
        if (bcd !== e[15:0]) begin
            fails++;
            $display("FAIL count_10: got %h expected %h", bcd, e[15:0]);
        end
    endtask

    task automatic test_pause_resume();
        press_start();
        exp_q.push_back(32'd0);
        e = exp_q.pop_front();
        tests++;
        if (running !== e[0]) begin
            fails++;
            $display("FAIL pause_running: got %b expected %b", running, e[0]);
        end
        for (int i = 0; i < 50; i++) exp_q.push_back(32'h0010);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests++;
            if (bcd !== e[15:0]) begin
                fails++;
                $display("FAIL pause_hold cycle %0d: got %h expected %h", i, bcd, e[15:0]);
            end
        end
        exp_q.push_back({15'd0, 1'b1, 16'h0010});
        exp_q.push_back({15'd0, 1'b1, 16'h0010});
        exp_q.push_back({15'd0, 1'b1, 16'h0011});
        press_start();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            e = exp_q.pop_front();
            tests++;
            if ({running, bcd} !== e[16:0]) begin
                fails++;
                $display("FAIL resume_phase step %0d: got %h expected %h", i, {running, bcd}, e[16:0]);
            end
        end
    endtask

    task automatic test_wrap();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        exp_q.push_back({14'd0, 1'b0, 1'b0, 16'h0000});
        e = exp_q.pop_front();
        tests++;
        if ({ovf, running, bcd} !== e[17:0]) begin
            fails++;
            $display("FAIL wrap_pre_clear: got %h expected %h", {ovf, running, bcd}, e[17:0]);
        end
        exp_q.push_back({14'd0, 1'b0, 1'b1, 16'h5999});
        exp_q.push_back({14'd0, 1'b1, 1'b1, 16'h0000});
        exp_q.push_back({14'd0, 1'b1, 1'b1, 16'h0001});
        press_start();
        repeat (23996) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) repeat (4) @(negedge clk);
            e = exp_q.pop_front();
            tests++;
            if ({ovf, running, bcd} !== e[17:0]) begin
                fails++;
                $display("FAIL wrap step %0d: got %h expected %h", i, {ovf, running, bcd}, e[17:0]);
            end
        end
        exp_q.push_back(32'd1);
        exp_q.push_back({14'd0, 1'b0, 1'b0, 16'h0000});
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        e = exp_q.pop_front();
        tests++;
        if (ovf !== e[0]) begin
            fails++;
            $display("FAIL ovf_sticky: got %b expected %b", ovf, e[0]);
        end
        @(negedge clk);
        e = exp_q.pop_front();
        tests++;
        if ({ovf, running, bcd} !== e[17:0]) begin
            fails++;
            $display("FAIL ovf_clear: got %h expected %h", {ovf, running, bcd}, e[17:0]);
        end
    endtask

    task automatic test_simultaneous();
        exp_q.push_back({15'd0, 1'b1, 16'h0002});
        exp_q.push_back({15'd0, 1'b0, 16'h0000});
        exp_q.push_back({15'd0, 1'b0, 16'h0000});
        press_start();
        repeat (10) @(negedge clk);
        e = exp_q.pop_front();
        tests++;
        if ({running, bcd} !== e[16:0]) begin
            fails++;
            $display("FAIL simul_pre: got %h expected %h", {running, bcd}, e[16:0]);
        end
        start_stop = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
        clear = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        tests++;
        if ({running, bcd} !== e[16:0]) begin
            fails++;
            $display("FAIL simul_clear: got %h expected %h", {running, bcd}, e[16:0]);
        end
        repeat (8) @(negedge clk);
        e = exp_q.pop_front();
        tests++;
        if ({running, bcd} !== e[16:0]) begin
            fails++;
            $display("FAIL simul_stays_idle: got %h expected %h", {running, bcd}, e[16:0]);
        end
    endtask

    task automatic test_scan();
        logic [3:0] prev;
        bit found;
        exp_q.push_back(32'h1234);
        press_start();
        repeat (4936) @(negedge clk);
        e = exp_q.pop_front();
        tests++;
        if (bcd !== e[15:0]) begin
            fails++;
            $display("FAIL scan_preload: got %h expected %h", bcd, e[15:0]);
        end
        press_start();
        found = 1'b0;
        prev = sel;
        for (int i = 0; i < 16 && !found; i++) begin
            @(negedge clk);
            if (sel == 4'b1110 && prev != 4'b1110) found = 1'b1;
            prev = sel;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL scan_sync: sel never entered 1110, last %b", sel);
        end
        exp_q.push_back({23'd0, 4'b1110, 4'd4, 1'b0});
        exp_q.push_back({23'd0, 4'b1110, 4'd4, 1'b0});
        exp_q.push_back({23'd0, 4'b1101, 4'd3, 1'b0});
        exp_q.push_back({23'd0, 4'b1101, 4'd3, 1'b0});
        exp_q.push_back({23'd0, 4'b1011, 4'd2, 1'b1});
        exp_q.push_back({23'd0, 4'b1011, 4'd2, 1'b1});
        exp_q.push_back({23'd0, 4'b0111, 4'd1, 1'b0});
        exp_q.push_back({23'd0, 4'b0111, 4'd1, 1'b0});
        exp_q.push_back({23'd0, 4'b1110, 4'd4, 1'b0});
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            e = exp_q.pop_front();
            tests++;
            if ({sel, digit, dp} !== e[8:0]) begin
                fails++;
                $display("FAIL scan cycle %0d: got sel/digit/dp %b/%0d/%b expected %b/%0d/%b",
                         i, sel, digit, dp, e[8:5], e[4:1], e[0]);
            end
        end
    endtask

    task automatic test_hold();
        int toggles;
        logic prev_run;
        exp_q.push_back({31'd1, 1'b1});
        toggles = 0;
        prev_run = running;
        start_stop = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (running != prev_run) toggles++;
            prev_run = running;
        end
        start_stop = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        tests++;
        if ({toggles[30:0], running} !== e) begin
            fails++;
            $display("FAIL hold_one_toggle: got toggles %0d running %b expected toggles 1 running 1", toggles, running);
        end
    endtask

    task automatic test_async_reset();
        exp_q.push_back(pk(16'h0000, 4'b1110, 4'd0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back({15'd0, 1'b0, 16'h0000});
        exp_q.push_back(32'd1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        e = exp_q.pop_front();
        tests++;
        if (snap() !== e) begin
            fails++;
            $display("FAIL async_reset: got %h expected %h", snap(), e);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        e = exp_q.pop_front();
        tests++;
        if ({running, bcd} !== e[16:0]) begin
            fails++;
            $display("FAIL post_reset_idle: got %h expected %h", {running, bcd}, e[16:0]);
        end
        press_start();
        e = exp_q.pop_front();
        tests++;
        if (running !== e[0]) begin
            fails++;
            $display("FAIL post_reset_start: got %b expected %b", running, e[0]);
        end
    endtask

    initial begin
        test_reset();
        test_start_count();
        test_pause_resume();
        test_wrap();
        test_simultaneous();
        test_scan();
        test_hold();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
